// File: rtl/piso_serializer_if.sv
// Handshake bundle for piso_serializer: load side (word in) and stream side (symbols out).
// slave = the serializer, master = the environment driving words and consuming symbols.
interface piso_serializer_if #(
  parameter int unsigned SIZE_DATA_IN  = 8,
  parameter int unsigned SIZE_DATA_OUT = 1
);
  logic                     i_load;
  logic [SIZE_DATA_IN-1:0]  i_data;
  logic                     o_ready;
  logic [SIZE_DATA_OUT-1:0] o_data;
  logic                     o_valid;
  logic                     i_ready;
  logic                     o_last;
  logic                     o_done;

  modport slave (
    input  i_load, i_data, i_ready,
    output o_ready, o_data, o_valid, o_last, o_done
  );

  modport master (
    output i_load, i_data, i_ready,
    input  o_ready, o_data, o_valid, o_last, o_done
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out converter: one SIZE_DATA_IN word in, DEPTH symbols out with last/done.
// Optional one-entry holding register for bubble-free back-to-back words: PISO_SKID_BUFFER_EN.
module piso_serializer #(
  parameter int unsigned SIZE_DATA_IN  = 8,
  parameter int unsigned SIZE_DATA_OUT = 1,
  parameter bit          MSB_FIRST     = 1'b1
) (
  input logic               i_clk,
  input logic               i_rst_n,
  piso_serializer_if.slave  bus_io
);

  localparam int unsigned DEPTH = SIZE_DATA_IN / SIZE_DATA_OUT;
  localparam int unsigned CW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if ((SIZE_DATA_IN % SIZE_DATA_OUT) != 0 || DEPTH < 2) begin : gen_param_err
    $error("piso_serializer: SIZE_DATA_IN must be a multiple of SIZE_DATA_OUT with DEPTH >= 2");
  end

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e                  state_q, state_d;
  logic [SIZE_DATA_IN-1:0] shift_q, shift_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    done_q, done_d;

`ifdef PISO_SKID_BUFFER_EN
  logic [SIZE_DATA_IN-1:0] hold_q, hold_d;
  logic                    hold_full_q, hold_full_d;
`endif

  logic                     valid;
  logic                     ready;
  logic                     last;
  logic                     xfer;
  logic                     load_acc;
  logic [SIZE_DATA_OUT-1:0] sym;
  logic [SIZE_DATA_IN-1:0]  shifted;

  // Output symbol is taken straight from the register, never from i_data.
  if (MSB_FIRST) begin : gen_msb
    assign sym     = shift_q[SIZE_DATA_IN-1 -: SIZE_DATA_OUT];
    assign shifted = shift_q << SIZE_DATA_OUT;
  end else begin : gen_lsb
    assign sym     = shift_q[SIZE_DATA_OUT-1:0];
    assign shifted = shift_q >> SIZE_DATA_OUT;
  end

  always_comb begin
    valid = (state_q == StShift);
    last  = valid && (cnt_q == CW'(DEPTH - 1));
`ifdef PISO_SKID_BUFFER_EN
    ready = ~hold_full_q;
`else
    ready = (state_q == StIdle);
`endif
    xfer     = valid & bus_io.i_ready;
    load_acc = bus_io.i_load & ready;
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef PISO_SKID_BUFFER_EN
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (load_acc) begin
          shift_d = bus_io.i_data;
          cnt_d   = '0;
          state_d = StShift;
        end
      end

      StShift: begin
`ifdef PISO_SKID_BUFFER_EN
        // A load landing on the final transfer goes straight to the shift register instead.
        if (load_acc && !(xfer && last)) begin
          hold_d      = bus_io.i_data;
          hold_full_d = 1'b1;
        end
`endif
        if (xfer) begin
          shift_d = shifted;
          cnt_d   = cnt_q + CW'(1);
          if (last) begin
            done_d = 1'b1;
            cnt_d  = '0;
`ifdef PISO_SKID_BUFFER_EN
            if (hold_full_q) begin
              shift_d     = hold_q;
              hold_full_d = 1'b0;
            end else if (load_acc) begin
              shift_d = bus_io.i_data;
            end else begin
              state_d = StIdle;
            end
`else
            state_d = StIdle;
`endif
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

`ifdef PISO_SKID_BUFFER_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end
`endif

  assign bus_io.o_ready = ready;
  assign bus_io.o_valid = valid;
  assign bus_io.o_data  = sym;
  assign bus_io.o_last  = last;
  assign bus_io.o_done  = done_q;

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in serial-out converter; the transmit-side counterpart of the serial-to-parallel deserializer in the Viterbi datapath.
- Accepts one SIZE_DATA_IN-bit word through a valid/ready load handshake.
- Emits it as DEPTH = SIZE_DATA_IN/SIZE_DATA_OUT symbols through a valid/ready stream, with last and done markers.
- Feeds the encoder/channel model from bus-side words.

Parameters:
- SIZE_DATA_IN, 8, parallel word width in bits.
- SIZE_DATA_OUT, 1, serial symbol width in bits. SIZE_DATA_IN must be a multiple of SIZE_DATA_OUT, and DEPTH must be ≥ 2; otherwise $error at elaboration.
- MSB_FIRST, 1, 1 = emit most-significant symbol first; 0 = emit least-significant symbol first.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_load  input  1  parallel word valid.
- i_data  input  SIZE_DATA_IN  parallel word.
- o_ready  output  1  block can accept a word this cycle.
- o_data  output  SIZE_DATA_OUT  current serial symbol.
- o_valid  output  1  o_data is valid.
- i_ready  input  1  downstream accepts o_data this cycle.
- o_last  output  1  current symbol is the final symbol of its word.
- o_done  output  1  one-cycle pulse after the final symbol of a word is transferred.

Behaviour:
- One clock; reset is asynchronous and active-low. All flops clear immediately on i_rst_n low.
- Reset values: o_valid=0, o_data=0, o_last=0, o_done=0, o_ready=1 (combinational from IDLE), shift register=0, symbol counter=0, state=IDLE.
- Symbol counter width is $clog2(DEPTH).
- FSM has two states, IDLE and SHIFT.
- IDLE:
  - o_ready=1, o_valid=0.
  - Load accept (i_load & o_ready) captures i_data into the shift register, clears the counter, and moves to SHIFT.
  - o_valid rises the next cycle, so load-to-first-symbol latency is 1 cycle.
- SHIFT:
  - o_valid=1. Base build drives o_ready=0.
  - o_data is the top symbol when MSB_FIRST=1, else the bottom symbol. It comes straight from the register, so there is no combinational path from i_data.
  - Transfer = o_valid & i_ready.
  - On a transfer: shift one symbol toward the output end, zero-fill the vacated end, and increment the counter.
  - With i_ready=0: o_data, o_valid, o_last and the counter hold unchanged, for any number of cycles.
  - o_last=1 exactly while counter == DEPTH-1.
  - On a transfer with o_last=1: go to IDLE, and pulse o_done=1 on the following cycle only.
- i_load while o_ready=0: ignored. No capture, no state change, and the word in flight is unaffected.
- Throughput (base build): DEPTH+1 cycles per word with i_ready tied high, i.e. one idle bubble between words.
- Reset asserted mid-word: the word is abandoned, no o_done is issued, and all outputs return to reset values. The first cycle after release is IDLE.
- i_data is sampled only on an accepted load; it may change freely otherwise.

Optional Feature:
- Macro: PISO_SKID_BUFFER_EN.
- Defined:
  - Adds a one-entry holding register; o_ready = ~hold_full in any state.
  - A load accepted in SHIFT goes into the holding register.
  - On the last-symbol transfer with the holding register full, the held word moves into the shift register and the counter clears. State stays SHIFT and o_valid stays 1, so back-to-back words run with zero bubbles (DEPTH cycles per word).
  - A load coinciding with the last-symbol transfer while the holding register is empty loads directly into the shift register. It neither fills the holding register nor drops to IDLE.
  - o_done still pulses once per completed word.
  - Reset clears the holding register.
- Undefined: holding-register logic is absent and behaviour is exactly the base build above.

Test Plan:
- MSB_FIRST=1, i_ready=1, load 0xB4 at cycle 0 → o_valid cycles 1–8 with o_data 1,0,1,1,0,1,0,0. o_last only at cycle 8, o_done only at cycle 9, o_ready=1 again at cycle 9.
- MSB_FIRST=0, load 0xB4 → symbols 0,0,1,0,1,1,0,1, with o_last on the 8th symbol.
- Backpressure: load 0xB4, drop i_ready for cycles 3–5 → o_data holds 1 (third symbol) during the stall. The sequence resumes unchanged, and o_last/o_done are delayed by 3 cycles.
- Load 0x5A while in SHIFT, base build → ignored; output sequence and o_done are unchanged, and the next word is accepted only when o_ready=1.
- Reset asserted at the 4th symbol → o_valid=0 and o_data=0 immediately, no o_done. A later load of 0xFF emits eight 1s normally.
- PISO_SKID_BUFFER_EN, i_ready=1, loads 0xB4 then 0x0F → 16 consecutive valid symbols 1,0,1,1,0,1,0,0,0,0,0,0,1,1,1,1 with no gap. o_last at symbols 8 and 16, two o_done pulses.
